// File: rtl/fetch_ctrl.sv
// Instruction-fetch and jump-issue controller: presents pc to the synchronous ROM,
// delivers each valid word one cycle later and steers the PC for jumps and HALT.
module fetch_ctrl #(
    parameter int          IW       = 16,
    parameter logic [3:0]  JMP_OPC  = 4'hA,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    pc,
    input  logic [7:0]    regA_value,
    input  logic [IW-1:0] rom_data,
    input  logic          resume,
    output logic [7:0]    rom_addr,
    output logic [IW-1:0] instr,
    output logic [7:0]    instr_pc,
    output logic          instr_valid,
    output logic          is_jump,
    output logic [3:0]    jump_cond,
    output logic [7:0]    target_addr,
    output logic          halted,
    output logic [7:0]    squash_count
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] addr_q;
    logic [7:0] halt_pc;
    logic [3:0] cond;
    logic [3:0] opc;
    logic [7:0] lit;
    logic       is_jmp_opc;
    logic       taken;

    assign rom_addr   = pc;
    assign cond       = rom_data[IW-1 -: 4];
    assign opc        = rom_data[IW-5 -: 4];
    assign lit        = rom_data[7:0];
    assign is_jmp_opc = (opc == JMP_OPC);
    // Must match the PC's own jump condition exactly, or the squash slot desyncs.
    assign taken      = is_jmp_opc &&
                        ((cond == 4'hF) || ((cond == 4'h1) && (regA_value == 8'd0)));
    assign halted     = (state == S_HALT);

    // instr_valid is a one-cycle strobe with no backpressure: downstream must
    // accept instr/instr_pc in the cycle the strobe is high.
    always_comb begin
        is_jump     = 1'b0;
        jump_cond   = 4'h0;
        target_addr = 8'h00;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    if (is_jmp_opc) begin
                        is_jump     = 1'b1;
                        jump_cond   = cond;
                        target_addr = lit;
                    end
                end
                S_HALT: begin
                    is_jump     = 1'b1;
                    jump_cond   = 4'hF;
                    target_addr = resume ? (halt_pc + 8'd1) : halt_pc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BOOT;
            addr_q       <= 8'h00;
            halt_pc      <= 8'h00;
            instr        <= '0;
            instr_pc     <= 8'h00;
            instr_valid  <= 1'b0;
            squash_count <= 8'h00;
        end else begin
            addr_q      <= pc;
            instr_valid <= 1'b0;
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    instr       <= rom_data;
                    instr_pc    <= addr_q;
                    instr_valid <= 1'b1;
                    if (taken) begin
                        state <= S_SQUASH;
                    end else if (opc == HALT_OPC) begin
                        halt_pc <= addr_q;
                        state   <= S_HALT;
                    end
                end
                S_SQUASH: begin
                    if (squash_count != 8'hFF)
                        squash_count <= squash_count + 8'd1;
                    state <= S_RUN;
                end
                S_HALT: begin
                    if (resume)
                        state <= S_SQUASH;
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural PC and synchronous ROM close the
// loop around the DUT; each step checks hand-computed cycle-exact outputs.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic [7:0]  reg_a;
    logic [15:0] rom_data;
    logic        resume;
    logic [7:0]  rom_addr;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        is_jump;
    logic [3:0]  jump_cond;
    logic [7:0]  target_addr;
    logic        halted;
    logic [7:0]  squash_count;

    logic [15:0] rom [256];
    int passed = 0;
    int total  = 0;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .regA_value   (reg_a),
        .rom_data     (rom_data),
        .resume       (resume),
        .rom_addr     (rom_addr),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .is_jump      (is_jump),
        .jump_cond    (jump_cond),
        .target_addr  (target_addr),
        .halted       (halted),
        .squash_count (squash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC: follows a jump when its condition holds, otherwise increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= 8'h00;
        else if (is_jump && (jump_cond == 4'hF || (jump_cond == 4'h1 && reg_a == 8'h00)))
            pc <= target_addr;
        else
            pc <= pc + 8'd1;
    end

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 256; i++) rom[i] = {4'h0, 4'h1, 8'(i)};
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        resume = 1'b0;
        step();
        step();
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_squash", squash_count, 0);
        chk("rst_is_jump", is_jump, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_rom_addr", rom_addr, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        resume = 1'b0;
        reg_a  = 8'h05;

        // Sequential fetch
        fill_nops();
        reset_dut();
        step();
        chk("boot_no_valid", instr_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("seq_valid", instr_valid, 1);
            chk("seq_pc", instr_pc, k);
            chk("seq_instr", instr, {8'h01, 8'(k)});
        end
        chk("seq_squash", squash_count, 0);

        // JMP, plus a jump sitting in the squashed slot
        fill_nops();
        rom[8'h02] = 16'hFA10;
        rom[8'h10] = 16'hFA30;
        rom[8'h11] = 16'hFA40;
        reset_dut();
        step();
        step();
        chk("jmp_pc0", instr_pc, 0);
        step();
        chk("jmp_is_jump", is_jump, 1);
        chk("jmp_target", target_addr, 8'h10);
        chk("jmp_cond", jump_cond, 4'hF);
        step();
        chk("jmp_deliv_pc", instr_pc, 2);
        chk("jmp_deliv_instr", instr, 16'hFA10);
        chk("jmp_squash_no_jump", is_jump, 0);
        step();
        chk("jmp_squash_valid", instr_valid, 0);
        chk("jmp_squash_cnt", squash_count, 1);
        chk("jmp2_target", target_addr, 8'h30);
        step();
        chk("jmp2_deliv_pc", instr_pc, 8'h10);
        chk("jmp2_valid", instr_valid, 1);
        chk("squashed_jmp_ignored", is_jump, 0);
        step();
        chk("jmp2_squash_valid", instr_valid, 0);
        chk("jmp2_squash_cnt", squash_count, 2);
        step();
        chk("jmp2_dest_valid", instr_valid, 1);
        chk("jmp2_dest_pc", instr_pc, 8'h30);

        // JEQ not taken
        fill_nops();
        rom[8'h04] = 16'h1A20;
        reg_a = 8'h05;
        reset_dut();
        repeat (5) step();
        chk("jeq_nt_is_jump", is_jump, 1);
        chk("jeq_nt_cond", jump_cond, 4'h1);
        chk("jeq_nt_target", target_addr, 8'h20);
        step();
        chk("jeq_nt_deliv", instr_pc, 4);
        step();
        chk("jeq_nt_next_valid", instr_valid, 1);
        chk("jeq_nt_next_pc", instr_pc, 5);
        chk("jeq_nt_squash", squash_count, 0);

        // JEQ taken
        reg_a = 8'h00;
        reset_dut();
        repeat (5) step();
        chk("jeq_t_is_jump", is_jump, 1);
        step();
        chk("jeq_t_deliv", instr_pc, 4);
        step();
        chk("jeq_t_squash_valid", instr_valid, 0);
        chk("jeq_t_squash", squash_count, 1);
        step();
        chk("jeq_t_next_valid", instr_valid, 1);
        chk("jeq_t_next_pc", instr_pc, 8'h20);

        // HALT and resume
        fill_nops();
        rom[8'h06] = 16'h0F00;
        reg_a = 8'h05;
        reset_dut();
        repeat (7) step();
        chk("halt_word_no_jump", is_jump, 0);
        chk("halt_not_yet", halted, 0);
        step();
        chk("halt_deliv_valid", instr_valid, 1);
        chk("halt_deliv_pc", instr_pc, 6);
        chk("halt_deliv_instr", instr, 16'h0F00);
        chk("halt_halted", halted, 1);
        chk("halt_is_jump", is_jump, 1);
        chk("halt_target", target_addr, 6);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_no_valid", instr_valid, 0);
            chk("halt_still", halted, 1);
            chk("halt_pc_pinned", pc, 6);
        end
        resume = 1'b1;
        #1;
        chk("resume_target", target_addr, 7);
        chk("resume_is_jump", is_jump, 1);
        step();
        resume = 1'b0;
        chk("resume_halted_low", halted, 0);
        chk("resume_no_valid", instr_valid, 0);
        chk("resume_pc", pc, 7);
        step();
        chk("resume_squash", squash_count, 1);
        chk("resume_squash_valid", instr_valid, 0);
        step();
        chk("resume_next_valid", instr_valid, 1);
        chk("resume_next_pc", instr_pc, 7);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("stray_resume_pc", instr_pc, 8);
        chk("stray_resume_valid", instr_valid, 1);
        chk("stray_resume_squash", squash_count, 1);

        // Reset while halted
        reset_dut();
        repeat (10) step();
        chk("mid_halt_halted", halted, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_is_jump", is_jump, 0);
        chk("mid_rst_valid", instr_valid, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_boot", instr_valid, 0);
        step();
        chk("mid_rst_refetch_valid", instr_valid, 1);
        chk("mid_rst_refetch_pc", instr_pc, 0);

        // Saturation: every word jumps to 0, one squash per two cycles
        for (int i = 0; i < 256; i++) rom[i] = 16'hFA00;
        reset_dut();
        repeat (201) step();
        chk("sat_mid", squash_count, 100);
        repeat (500) step();
        chk("sat_final", squash_count, 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch and jump-issue controller: the producer side of the PC's jump interface.
- Drives the instruction ROM address from the PC value and captures the synchronous ROM word one cycle later.
- Presents each valid instruction downstream and decodes jump instructions into is_jump / jump_cond / target_addr for the PC.
- Squashes the wrong-path word after a taken jump, and implements HALT/resume by steering the PC.

Parameters:
- IW, 16, instruction width; fields are [IW-1:IW-4] = cond, [IW-5:IW-8] = opcode, [7:0] = literal.
- JMP_OPC, 4'hA, opcode marking a jump instruction.
- HALT_OPC, 4'hF, opcode marking HALT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset; also routed to the PC in the integrated core.
- pc  in  8  current PC value.
- regA_value  in  8  register A value, used to resolve JEQ.
- rom_data  in  IW  ROM word for the address presented on the previous cycle.
- resume  in  1  single-cycle pulse that leaves HALT.
- rom_addr  out  8  ROM read address; combinational, equal to pc.
- instr  out  IW  registered delivered instruction.
- instr_pc  out  8  registered address of instr.
- instr_valid  out  1  one-cycle strobe per delivered instruction.
- is_jump  out  1  jump request to PC; combinational, sampled by PC on the same edge.
- jump_cond  out  4  1111 = JMP, 0001 = JEQ.
- target_addr  out  8  jump destination.
- halted  out  1  high while in HALT.
- squash_count  out  8  number of discarded words, saturating at 255.

Behaviour:
- Clock and reset: one clock, clk, rising edge. rst is asynchronous, active-high.
  - During reset: state = BOOT; instr, instr_pc, instr_valid, squash_count, halted = 0; addr_q = 0.
  - Combinational jump outputs are 0 while rst is high or in BOOT.
- Address capture: addr_q <= pc every cycle, so rom_data in cycle n belongs to addr_q, i.e. pc of cycle n-1.
- Decode fields: cond = rom_data[IW-1:IW-4], opc = rom_data[IW-5:IW-8], lit = rom_data[7:0].
- taken = (opc == JMP_OPC) && (cond == 1111 || (cond == 0001 && regA_value == 0)). This duplicates the PC's condition exactly.
- States:
  - BOOT: rom_data is invalid; discard it (not counted); go to RUN.
  - RUN: word is valid.
    - Next cycle: instr <= rom_data, instr_pc <= addr_q, instr_valid = 1.
    - If opc == JMP_OPC: is_jump = 1, jump_cond = cond, target_addr = lit, whether or not the jump is taken.
    - If taken: go to SQUASH.
    - Else if opc == HALT_OPC: latch halt_pc = addr_q and go to HALT. The HALT word is delivered once; no jump is issued in that cycle.
    - Else: stay in RUN.
  - SQUASH: the current word is the wrong path.
    - No delivery and no jump output; squash_count += 1 (saturating); go to RUN.
    - Opcodes (jump or HALT) in a squashed word are ignored.
  - HALT: ignore rom_data (not counted); halted = 1; no delivery.
    - Each cycle drive is_jump = 1, jump_cond = 1111, target_addr = halt_pc. After at most 2 cycles the PC is pinned at halt_pc.
    - If resume = 1: drive target_addr = halt_pc + 1 (8-bit wrap, 255 -> 0) instead and go to SQUASH. halted deasserts on the next cycle.
- resume outside HALT is ignored.
- rst asserted mid-operation aborts any state immediately. Nothing is delivered until RUN, at earliest 2 cycles after rst deasserts.
- Single-slot penalty: a taken jump costs exactly one squashed word; a non-taken JEQ costs none.

Test Plan:
- Reset and sequential fetch: release rst; ROM[0..3] = non-jump words -> instr_valid pulses with instr_pc = 0, 1, 2, 3 on consecutive cycles after the BOOT cycle; squash_count = 0.
- JMP: ROM[2] = {1111, JMP_OPC, 8'h10} -> is_jump = 1, target_addr = 0x10 in the cycle the word appears; word for address 3 squashed (squash_count = 1); next delivered instr_pc = 0x10.
- JEQ both ways: ROM[4] = {0001, JMP_OPC, 8'h20}.
  - With regA_value = 5: is_jump = 1, no squash, next instr_pc = 5.
  - With regA_value = 0: squash, next instr_pc = 0x20.
- Jump in squashed slot: ROM[0x10] = JMP 0x30, ROM[0x11] = JMP 0x40 -> only the 0x30 jump acts; the 0x11 word is squashed; next instr_pc = 0x30.
- HALT and resume: ROM[6] = HALT -> HALT delivered once; halted = 1; PC pinned at 6 with no further instr_valid for 10 cycles; resume pulse -> target_addr = 7, one squash, next instr_pc = 7.
- Reset mid-HALT and saturation:
  - Assert rst during HALT -> halted = 0 immediately, refetch resumes from instr_pc = 0.
  - 300 taken jumps -> squash_count = 255.
